booth_mac_ctrl: RTL
===================

Name: booth_mac_ctrl

Overview:
- Sequencer and accumulator that drives the 4x4 signed Booth multiplier and consumes its 8-bit product.
- Accepts operand pairs over a valid/ready handshake, issues `start` to the multiplier and waits for the product, then adds the sign-extended product into a saturating accumulator.
- Sits between the operand source (switch/register front-end) and the multiplier, and owns the multiplier's start/busy handshake.

Parameters:
- ACC_W, 12, accumulator width in bits (signed two's complement, minimum 8).
- MUL_LATENCY, 0, minimum cycles spent in WAIT before the product is sampled (0 = combinational multiplier).
- TIMEOUT, 15, maximum WAIT cycles before abort (must be > MUL_LATENCY).
- CNT_W, 8, width of the accumulated-sample counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- multiplicand_in  in  4  signed operand A.
- multiplier_in  in  4  signed operand B.
- clear  in  1  synchronous clear of acc_out, sample_cnt and overflow.
- mul_multiplicand  out  4  operand A to the multiplier (registered).
- mul_multiplier  out  4  operand B to the multiplier (registered).
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_busy  in  1  multiplier busy (tie 0 for a combinational multiplier).
- mul_product  in  8  signed product from the multiplier.
- acc_out  out  ACC_W  signed accumulator value.
- acc_valid  out  1  one-cycle pulse: acc_out was just updated.
- sample_cnt  out  CNT_W  number of products accumulated; wraps modulo 2^CNT_W.
- overflow  out  1  sticky: saturation has occurred.
- timeout_err  out  1  sticky: the multiplier failed to finish within TIMEOUT cycles.

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. State resets to IDLE, and operand registers and the wait counter reset to 0.
- IDLE:
  - in_ready = 1.
  - If in_valid = 1, latch both operands into mul_multiplicand/mul_multiplier and go to ISSUE.
- ISSUE:
  - mul_start = 1 for exactly this cycle.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - The wait counter increments each cycle.
  - When wait_cnt >= MUL_LATENCY and mul_busy = 0, sample mul_product on this edge: acc <= sat(acc + sext(mul_product)), sample_cnt += 1, go to ACCUM.
  - Otherwise, if wait_cnt == TIMEOUT, set timeout_err, leave acc unchanged and go to IDLE.
- ACCUM:
  - acc_valid = 1 for this single cycle, in_ready = 0.
  - Go to IDLE.
- Handshake:
  - Transfer occurs only when in_valid && in_ready.
  - in_ready is 0 in ISSUE, WAIT and ACCUM, so there is one outstanding operation at most.
  - Operands presented while in_ready = 0 are not captured; the source holds them.
- Latency with MUL_LATENCY = 0 and mul_busy = 0: accept at edge T0, then ISSUE in T1, WAIT in T2, and acc_valid in T3.
- Throughput: one product per 4 cycles.
- Operand hold: mul_multiplicand and mul_multiplier hold their latched value until the next accept.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - A result above 2^(ACC_W-1)-1 clamps to that value; a result below -2^(ACC_W-1) clamps to that value.
  - Either clamp sets overflow.
- clear:
  - Honoured in every state.
  - It zeroes acc, sample_cnt, overflow and timeout_err, and does not change the state.
  - If the WAIT exit edge coincides with clear, acc <= sext(mul_product), sample_cnt <= 1, overflow <= 0.
  - If clear coincides with an IDLE accept, both take effect.
- Reset during an operation: returns to IDLE immediately with reset values; mul_start does not pulse on the reset cycle.
- sample_cnt wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package:
  - state encoding IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACCUM = 2'd3;
  - PRODUCT_W = 8;
  - OPERAND_W = 4.
- One natural sub-module: sat_add, a combinational signed saturating adder of ACC_W bits plus a sign-extended 8-bit input, returning sum and ovf.
- The FSM, counters and registers stay in booth_mac_ctrl.

Test Plan:
- Reset, then A = 3, B = 5 with mul_product driven from a Booth reference model -> mul_start pulses in T1, acc_valid in T3, acc_out = 15, sample_cnt = 1.
- Continue with A = -2, B = 7 (product -14) -> acc_out = 1. Then A = -8, B = -8 (product 64) -> acc_out = 65, sample_cnt = 3, overflow = 0.
- ACC_W = 8: repeat A = 7, B = 7 three times -> acc_out = 49, 98, then 127 with overflow = 1. Next, A = -8, B = 7 -> acc_out = 71, overflow stays 1.
- mul_busy held high 3 cycles with MUL_LATENCY = 2 -> product sampled on the first edge with busy = 0, and in_valid held high is ignored until ACCUM ends. With busy stuck high -> timeout_err = 1 after TIMEOUT WAIT cycles, acc unchanged, in_ready = 1 afterwards.
- clear asserted on the WAIT exit edge with acc = 40 and product 6 -> acc_out = 6, sample_cnt = 1, overflow = 0.
- reset asserted during WAIT -> next cycle: IDLE, in_ready = 1, acc_out = 0, acc_valid never pulses.

Source files
------------

// File: rtl/booth_mac_ctrl_pkg.sv
// Shared types and constants for the Booth multiplier sequencer/accumulator.
package booth_mac_ctrl_pkg;

    localparam int OPERAND_W = 4;
    localparam int PRODUCT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACCUM = 2'd3
    } state_t;

    // Width needed for a counter that must reach `timeout` (at least one bit).
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/booth_mac_ctrl_sat_add.sv
// Combinational signed saturating adder: ACC_W-bit accumulator plus a
// sign-extended product. The sum is formed one bit wider so both overflow
// directions are visible, then clamped to the ACC_W range.
module booth_mac_ctrl_sat_add
    import booth_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic signed [ACC_W-1:0]     acc,
    input  logic signed [PRODUCT_W-1:0] addend,
    output logic signed [ACC_W-1:0]     sum,
    output logic                        ovf
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] wide;

    // Add at ACC_W+1 bits; the top two bits disagree exactly when the result
    // left the representable range, and the top bit tells which way.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no path can infer a latch.
        wide = {acc[ACC_W-1], acc}
             + {{(ACC_W + 1 - PRODUCT_W){addend[PRODUCT_W-1]}}, addend};
        sum  = wide[ACC_W-1:0];
        ovf  = 1'b0;
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            ovf = 1'b1;
            sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/booth_mac_ctrl.sv
// Sequencer for a 4x4 signed Booth multiplier: accepts operand pairs over
// valid/ready, pulses mul_start, waits for the product (minimum latency,
// busy, timeout) and folds it into a saturating signed accumulator.
module booth_mac_ctrl
    import booth_mac_ctrl_pkg::*;
#(
    parameter int ACC_W       = 12,
    parameter int MUL_LATENCY = 0,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [OPERAND_W-1:0] multiplicand_in,
    input  logic signed [OPERAND_W-1:0] multiplier_in,
    input  logic                        clear,
    output logic signed [OPERAND_W-1:0] mul_multiplicand,
    output logic signed [OPERAND_W-1:0] mul_multiplier,
    output logic                        mul_start,
    input  logic                        mul_busy,
    input  logic signed [PRODUCT_W-1:0] mul_product,
    output logic signed [ACC_W-1:0]     acc_out,
    output logic                        acc_valid,
    output logic [CNT_W-1:0]            sample_cnt,
    output logic                        overflow,
    output logic                        timeout_err
);

    localparam int WAIT_W = wait_cnt_width(TIMEOUT);

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept;
    logic                sample;
    logic                abort;
    logic                lat_done;
    logic                timed_out;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    acc_ovf;

    // Compare as signed ints so a zero latency does not produce an
    // always-true unsigned comparison.
    assign lat_done  = (int'(wait_cnt) >= MUL_LATENCY);
    assign timed_out = (int'(wait_cnt) == TIMEOUT);

    // A clear on the sampling edge discards the old total, so the product
    // lands on zero rather than on the previous accumulator value.
    assign acc_base = clear ? '0 : acc_out;

    booth_mac_ctrl_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc    (acc_base),
        .addend (mul_product),
        .sum    (acc_sum),
        .ovf    (acc_ovf)
    );

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the handshake and pulse outputs, all from state.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sample    = 1'b0;
        abort     = 1'b0;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        acc_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_done && !mul_busy) begin
                    sample  = 1'b1;
                    state_d = ACCUM;
                end else if (timed_out) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                acc_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture on accept; the multiplier sees them held until the next accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else if (accept) begin
            mul_multiplicand <= multiplicand_in;
            mul_multiplier   <= multiplier_in;
        end
    end

    // Wait counter: zeroed while issuing, counts every WAIT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Accumulator, sample counter and sticky flags; clear applies in any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_out    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
        end else if (sample) begin
            acc_out    <= acc_sum;
            sample_cnt <= (clear ? '0 : sample_cnt) + CNT_W'(1);
            overflow   <= (overflow && !clear) || acc_ovf;
        end else if (clear) begin
            acc_out    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
        end
    end

    // Timeout flag: set by an aborted wait, dropped by clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (abort) begin
            timeout_err <= 1'b1;
        end else if (clear) begin
            timeout_err <= 1'b0;
        end
    end

endmodule
